// File: rtl/instr_decode_latch_if.sv
// Instruction/flag/interrupt bus between the datapath-side driver and the decode latch.
interface instr_decode_latch_if;
  logic        IRWrite;
  logic [31:0] memReadData;
  logic        flagWrite;
  logic        aluNeg;
  logic        aluZero;
  logic        irq;
  logic        irqAck;
  logic [31:0] instr;
  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rn;
  logic [3:0]  rd;
  logic [3:0]  rm;
  logic [23:0] imm24;
  logic        neg;
  logic        zr;
  logic        condPass;
  logic        instrValid;
  logic        irqPending;

  modport master (
    output IRWrite, memReadData, flagWrite, aluNeg, aluZero, irq, irqAck,
    input  instr, cond, op, funct, rn, rd, rm, imm24, neg, zr, condPass,
           instrValid, irqPending
  );

  modport slave (
    input  IRWrite, memReadData, flagWrite, aluNeg, aluZero, irq, irqAck,
    output instr, cond, op, funct, rn, rd, rm, imm24, neg, zr, condPass,
           instrValid, irqPending
  );
endinterface

// File: rtl/instr_decode_latch.sv
// Instruction register, N/Z flag register with condition evaluation, and interrupt edge latch.
// Define DECODE_IRQ_EN to build the interrupt pending FSM; otherwise irqPending is tied low.
module instr_decode_latch #(
  parameter logic [31:0] RESET_INSTR = 32'hE1A00000
) (
  input logic                 clock,
  input logic                 reset,
  instr_decode_latch_if.slave bus
);

  logic [31:0] instr_q, instr_d;
  logic        neg_q, neg_d;
  logic        zr_q, zr_d;
  logic        valid_q, valid_d;
  logic        cond_pass;

  always_comb begin
    instr_d = instr_q;
    neg_d   = neg_q;
    zr_d    = zr_q;
    valid_d = valid_q;
    if (bus.IRWrite) begin
      instr_d = bus.memReadData;
      valid_d = 1'b1;
    end
    if (bus.flagWrite) begin
      neg_d = bus.aluNeg;
      zr_d  = bus.aluZero;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      instr_q <= RESET_INSTR;
      neg_q   <= 1'b0;
      zr_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      neg_q   <= neg_d;
      zr_q    <= zr_d;
      valid_q <= valid_d;
    end
  end

  // Only N/Z are held, so C/V-based codes and 1111 never pass.
  always_comb begin
    cond_pass = 1'b0;
    case (instr_q[31:28])
      4'b0000: cond_pass = zr_q;
      4'b0001: cond_pass = ~zr_q;
      4'b0100: cond_pass = neg_q;
      4'b0101: cond_pass = ~neg_q;
      4'b1010: cond_pass = ~neg_q;
      4'b1011: cond_pass = neg_q;
      4'b1100: cond_pass = ~zr_q & ~neg_q;
      4'b1101: cond_pass = zr_q | neg_q;
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign bus.instr      = instr_q;
  assign bus.cond       = instr_q[31:28];
  assign bus.op         = instr_q[27:26];
  assign bus.funct      = instr_q[25:20];
  assign bus.rn         = instr_q[19:16];
  assign bus.rd         = instr_q[15:12];
  assign bus.rm         = instr_q[3:0];
  assign bus.imm24      = instr_q[23:0];
  assign bus.neg        = neg_q;
  assign bus.zr         = zr_q;
  assign bus.condPass   = cond_pass;
  assign bus.instrValid = valid_q;

`ifdef DECODE_IRQ_EN
  typedef enum logic {IDLE, PENDING} irq_state_t;

  irq_state_t state_q;
  logic       irq_prev_q;
  logic       irq_rise;

  assign irq_rise = bus.irq & ~irq_prev_q;

  // A rise coincident with an acknowledge keeps the request pending.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      irq_prev_q <= 1'b0;
    end else begin
      irq_prev_q <= bus.irq;
      case (state_q)
        IDLE:    if (irq_rise) state_q <= PENDING;
        PENDING: if (bus.irqAck && !irq_rise) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.irqPending = (state_q == PENDING);
`else
  logic irq_unused;
  assign irq_unused     = bus.irq ^ bus.irqAck;
  assign bus.irqPending = 1'b0;
`endif

endmodule

// File: doc/instr_decode_latch.md
# instr_decode_latch

Instruction and status latch that sits directly upstream of the multicycle control unit. Captures the fetched instruction word on `IRWrite` and slices it into the `cond`/`op`/`funct`/`rd` fields the control unit decodes. Holds the N/Z status flags it reads as `neg`/`zr` and evaluates the condition code against them. Also edge-detects the external interrupt request and holds it pending until the control unit acknowledges it.

## Interface
- `RESET_INSTR`, 32'hE1A00000, instruction register reset value (MOV r0,r0; cond = AL).
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `IRWrite`  in  1  load `memReadData` into the instruction register.
- `memReadData`  in  32  instruction word from memory.
- `flagWrite`  in  1  load `aluNeg`/`aluZero` into the flag register.
- `aluNeg`  in  1  ALU result bit 31.
- `aluZero`  in  1  ALU result == 0.
- `irq`  in  1  interrupt request, level, synchronous to `clock`.
- `irqAck`  in  1  one-cycle acknowledge from control unit on entering its first interrupt state.
- `instr`  out  32  held instruction word.
- `cond`  out  4  `instr[31:28]`.
- `op`  out  2  `instr[27:26]`.
- `funct`  out  6  `instr[25:20]`.
- `rn`  out  4  `instr[19:16]`.
- `rd`  out  4  `instr[15:12]`.
- `rm`  out  4  `instr[3:0]`.
- `imm24`  out  24  `instr[23:0]`.
- `neg`  out  1  held N flag.
- `zr`  out  1  held Z flag.
- `condPass`  out  1  condition field satisfied by held flags.
- `instrValid`  out  1  at least one instruction captured since reset.
- `irqPending`  out  1  interrupt awaiting acknowledge.

## Operation
- Instruction register: on edge with `IRWrite`=1, `instr` <= `memReadData`. Otherwise it holds. All field outputs are pure slices of `instr`.
- `instrValid`: cleared by reset. Set on the first `IRWrite`. Sticky.
- Flag register: on edge with `flagWrite`=1, `neg` <= `aluNeg` and `zr` <= `aluZero`. Otherwise it holds.
- `condPass` is combinational from `cond`, `neg`, `zr`:
  - 0000 EQ = Z; 0001 NE = !Z.
  - 0100 MI = N; 0101 PL = !N.
  - 1010 GE = !N; 1011 LT = N.
  - 1100 GT = !Z & !N; 1101 LE = Z | N.
  - 1110 AL = 1.
  - All other codes (C/V-based, 1111) = 0.
- Interrupt logic uses a two-state FSM, IDLE and PENDING, with `irqPending` = (state == PENDING). `irqPrev` is a registered copy of `irq`; a rise is `irq & !irqPrev`.
  - IDLE -> PENDING on a rise.
  - PENDING -> IDLE on `irqAck`, unless a rise occurs in the same cycle (set wins; stays PENDING).
  - `irqAck` in IDLE is ignored.
  - A held-high `irq` produces exactly one pending event.
- `IRWrite`, `flagWrite` and interrupt logic are independent. Any combination in the same cycle takes effect together.

## Timing
- Reset, with `reset`=1 at an edge:
  - `instr` = `RESET_INSTR`, giving cond=1110, op=00, funct=011010, rd=rn=rm=0, imm24=24'hA00000.
  - `neg`=`zr`=0, `condPass`=1, `instrValid`=0.
  - `irqPending`=0, `irqPrev`=0.
  - Reset overrides every other input in that cycle, including a coincident `IRWrite`, `flagWrite` or `irq` rise.
- `IRWrite` asserted in cycle n: fields are valid from cycle n+1 and remain stable until the next `IRWrite`. This is the control unit's Decode cycle.
- `flagWrite` in cycle n: `neg`/`zr`/`condPass` update in cycle n+1. `condPass` in cycle n uses the old flags, so the control unit sees flags from before the current instruction's writeback.
- `irq` rise sampled at edge n: `irqPending`=1 in cycle n+1.
  - `irqAck` in cycle m clears it in cycle m+1.
  - Minimum pending pulse: 1 cycle.
- Reset mid-pending clears `irqPending`. A level `irq` still high after reset registers as a new rise on the first post-reset edge, because `irqPrev` resets to 0.

## Configuration
- `DECODE_IRQ_EN` defined: interrupt FSM and `irqPrev` are built as described.
- `DECODE_IRQ_EN` undefined: no interrupt state is built. `irqPending` is tied to 0, and `irq`/`irqAck` remain as ports but are ignored. All other behaviour is identical.

## Test plan
- Reset, then idle 3 cycles -> `instr`=E1A00000, cond=1110, funct=011010, `condPass`=1, `instrValid`=0, `irqPending`=0.
- `IRWrite`=1 with `memReadData`=0A000004 -> next cycle cond=0000, op=10, funct=100000, imm24=000004, `instrValid`=1. Then with `IRWrite`=0 and new data 12345678, all outputs hold.
- Fields of 0A000004 held. `flagWrite`=1, `aluZero`=1, `aluNeg`=0 -> `zr`=1 and `condPass`=1 next cycle. Then `flagWrite` with `aluZero`=0 -> `condPass`=0.
- Sweep all 16 cond codes against all 4 (N,Z) combinations -> `condPass` matches the Operation list. Codes 0010, 0011, 0110–1001 and 1111 give 0.
- `irq` high 5 cycles -> `irqPending`=1 one cycle after the rise, single event. `irqAck` pulse -> 0 next cycle. `irq` re-rise in the same cycle as `irqAck` -> `irqPending` stays 1. Build without `DECODE_IRQ_EN` -> `irqPending` always 0.
- `reset` asserted while `irqPending`=1 with coincident `IRWrite`/`flagWrite` -> all outputs at reset values next cycle. `irq` still high -> `irqPending`=1 one cycle after reset deasserts.
